// File: rtl/mem_initiator.sv
// mem_initiator: single-outstanding initiator for the read/write/ack memory handshake.
// Define MEM_INIT_RETRY_EN to re-issue a timed-out request up to MAX_RETRY more times.
module mem_initiator #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic              rsp_error,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ack
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;

`ifdef MEM_INIT_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    typedef enum logic [1:0] {IDLE, REQ, RSP, GAP} state_t;
    logic [RETRY_W-1:0] retry_cnt;
`else
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
`endif

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               timed_out;
    logic               retry_more;

    // Both channels transfer on a rising edge where valid and ready are high; valid never
    // depends on ready, and payload stays stable while valid waits for ready.
    assign cmd_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RSP);

    always_comb begin
        state_next = state;
        timed_out  = (wait_cnt == WAIT_W'(TIMEOUT - 1));
        retry_more = 1'b0;
`ifdef MEM_INIT_RETRY_EN
        retry_more = (retry_cnt < RETRY_W'(MAX_RETRY));
`endif
        case (state)
            IDLE: if (cmd_valid) state_next = REQ;
            REQ: begin
                if (ack) begin
                    state_next = RSP;
                end else if (timed_out) begin
`ifdef MEM_INIT_RETRY_EN
                    state_next = retry_more ? GAP : RSP;
`else
                    state_next = RSP;
`endif
                end
            end
            RSP: if (rsp_ready) state_next = IDLE;
`ifdef MEM_INIT_RETRY_EN
            GAP: state_next = REQ;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            read      <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
            rsp_error <= 1'b0;
`ifdef MEM_INIT_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr;
                        wdata     <= cmd_write ? cmd_wdata : '0;
                        read      <= !cmd_write;
                        write     <= cmd_write;
                        rsp_write <= cmd_write;
                        wait_cnt  <= '0;
`ifdef MEM_INIT_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                REQ: begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (ack) begin
                        // rdata is only meaningful alongside ack, and only for reads
                        rsp_rdata <= rsp_write ? '0 : rdata;
                        rsp_error <= 1'b0;
                        read      <= 1'b0;
                        write     <= 1'b0;
                    end else if (timed_out) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (retry_more) begin
`ifdef MEM_INIT_RETRY_EN
                            retry_cnt <= retry_cnt + RETRY_W'(1);
`endif
                        end else begin
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
`ifdef MEM_INIT_RETRY_EN
                GAP: begin
                    read     <= !rsp_write;
                    write    <= rsp_write;
                    wait_cnt <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
